// File: rtl/mem_stage_controller_pkg.sv
// Shared types for the data-memory stage controller.
//   DataAccess   : access size encoding carried down the pipeline
//   MemCtrlState : controller sequencing states
//   Byte-enable base patterns and an alignment helper
package mem_stage_controller_pkg;

  localparam int DataWidth = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } DataAccess;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } MemCtrlState;

  localparam logic [3:0] BeByte = 4'b0001;
  localparam logic [3:0] BeHalf = 4'b0011;
  localparam logic [3:0] BeWord = 4'b1111;

  // Size code 2'b11 is never legal; otherwise the offset must be a
  // multiple of the access size.
  function automatic logic isAligned(input logic [1:0] access, input logic [1:0] offset);
    case (access)
      2'b00:   isAligned = 1'b1;
      2'b01:   isAligned = ~offset[0];
      2'b10:   isAligned = (offset == 2'b00);
      default: isAligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_controller_aligner.sv
// mem_data_aligner: combinational byte-lane formatting.
//   access/offset/isUnsigned : size code, byte offset in word, zero-extend flag
//   storeData -> byteEnable, storeWord : lane enables and replicated store data
//   loadWord  -> loadData              : lane extraction plus sign/zero extension
module mem_data_aligner
  import mem_stage_controller_pkg::*;
(
  input  logic [1:0]           access,
  input  logic [1:0]           offset,
  input  logic                 isUnsigned,
  input  logic [DataWidth-1:0] storeData,
  input  logic [DataWidth-1:0] loadWord,
  output logic [3:0]           byteEnable,
  output logic [DataWidth-1:0] storeWord,
  output logic [DataWidth-1:0] loadData
);

  logic [DataWidth-1:0] shifted;

  always_comb begin
    shifted    = loadWord >> {offset, 3'b000};
    byteEnable = 4'b0000;
    storeWord  = '0;
    loadData   = '0;
    case (DataAccess'(access))
      BYTE: begin
        byteEnable = BeByte << offset;
        storeWord  = {4{storeData[7:0]}};
        loadData   = {{24{~isUnsigned & shifted[7]}}, shifted[7:0]};
      end
      HALF: begin
        // offset[0] is zero for any access that reaches the bus
        byteEnable = BeHalf << {offset[1], 1'b0};
        storeWord  = {2{storeData[15:0]}};
        loadData   = {{16{~isUnsigned & shifted[15]}}, shifted[15:0]};
      end
      WORD: begin
        byteEnable = BeWord;
        storeWord  = storeData;
        loadData   = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_controller.sv
// mem_stage_controller: sequences the data-memory access of the EX/MEM entry.
//   i_clock, i_reset (async, active-high)
//   EX/MEM side : i_isValid, i_addr, i_wrData, i_memWrEnable, i_memRdEnable,
//                 i_memAccess, i_memUnsigned
//   pipeline    : o_stall, o_rdData/o_rdValid, o_misaligned, o_busError
//   data bus    : o_busAddr, o_busRdEnable, o_busWrEnable, o_busByteEnable,
//                 o_busWrData, i_busRdData, i_busReady
// Flow: IDLE (latch request) -> REQ (wait ready/timeout) -> DONE (release
// the pipeline for exactly one advance) -> IDLE.
module mem_stage_controller
  import mem_stage_controller_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_isValid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  input  logic                  i_memWrEnable,
  input  logic                  i_memRdEnable,
  input  logic [1:0]            i_memAccess,
  input  logic                  i_memUnsigned,
  output logic                  o_stall,
  output logic [DATA_WIDTH-1:0] o_rdData,
  output logic                  o_rdValid,
  output logic                  o_misaligned,
  output logic                  o_busError,
  output logic [ADDR_WIDTH-1:0] o_busAddr,
  output logic                  o_busRdEnable,
  output logic                  o_busWrEnable,
  output logic [3:0]            o_busByteEnable,
  output logic [DATA_WIDTH-1:0] o_busWrData,
  input  logic [DATA_WIDTH-1:0] i_busRdData,
  input  logic                  i_busReady
);

  localparam int CntWidth = $clog2(TIMEOUT + 1);
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TIMEOUT - 1);

  MemCtrlState stateReg, stateNext;
  logic [CntWidth-1:0] countReg, countNext;

  logic [1:0] offsetReg, accessReg;
  logic       unsignedReg, isLoadReg, timedOutReg;
  logic [DATA_WIDTH-1:0] rdDataReg;

  logic accDetect, accAligned;
  logic startAccess, finishOk, finishTimeout;

  logic [3:0]            storeBe;
  logic [DATA_WIDTH-1:0] storeWord, loadData;
  logic [DATA_WIDTH-1:0] unusedStoreLoad, unusedLoadWord;
  logic [3:0]            unusedLoadBe;

  // Store path formats straight from the EX/MEM entry so the result can be
  // latched on the same edge that enters REQ.
  mem_data_aligner storeAligner (
    .access     (i_memAccess),
    .offset     (i_addr[1:0]),
    .isUnsigned (i_memUnsigned),
    .storeData  (i_wrData),
    .loadWord   ('0),
    .byteEnable (storeBe),
    .storeWord  (storeWord),
    .loadData   (unusedStoreLoad)
  );

  // Load path uses the size/offset captured at issue, since the bus word
  // only arrives during REQ.
  mem_data_aligner loadAligner (
    .access     (accessReg),
    .offset     (offsetReg),
    .isUnsigned (unsignedReg),
    .storeData  ('0),
    .loadWord   (i_busRdData),
    .byteEnable (unusedLoadBe),
    .storeWord  (unusedLoadWord),
    .loadData   (loadData)
  );

  // Held reset suppresses detection so stall cannot assert during reset.
  assign accDetect  = i_isValid & (i_memRdEnable | i_memWrEnable) & ~i_reset;
  assign accAligned = isAligned(i_memAccess, i_addr[1:0]);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      stateReg <= IDLE;
      countReg <= '0;
    end else begin
      stateReg <= stateNext;
      countReg <= countNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    countNext     = countReg;
    o_stall       = 1'b0;
    o_misaligned  = 1'b0;
    startAccess   = 1'b0;
    finishOk      = 1'b0;
    finishTimeout = 1'b0;
    case (stateReg)
      IDLE: begin
        if (accDetect) begin
          if (accAligned) begin
            o_stall     = 1'b1;
            startAccess = 1'b1;
            countNext   = '0;
            stateNext   = REQ;
          end else begin
            o_misaligned = 1'b1;
          end
        end
      end
      REQ: begin
        o_stall = 1'b1;
        if (i_busReady) begin
          finishOk  = 1'b1;
          stateNext = DONE;
        end else if (countReg == TimeoutLast) begin
          // This is the TIMEOUT-th REQ cycle without ready.
          finishTimeout = 1'b1;
          stateNext     = DONE;
        end else begin
          countNext = countReg + 1'b1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_busAddr       <= '0;
      o_busRdEnable   <= 1'b0;
      o_busWrEnable   <= 1'b0;
      o_busByteEnable <= 4'b0000;
      o_busWrData     <= '0;
      offsetReg       <= 2'b00;
      accessReg       <= 2'b00;
      unsignedReg     <= 1'b0;
      isLoadReg       <= 1'b0;
      timedOutReg     <= 1'b0;
      rdDataReg       <= '0;
    end else begin
      if (startAccess) begin
        // Store wins when both enables are set.
        o_busAddr       <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
        o_busRdEnable   <= ~i_memWrEnable;
        o_busWrEnable   <= i_memWrEnable;
        o_busByteEnable <= i_memWrEnable ? storeBe : 4'b0000;
        o_busWrData     <= storeWord;
        offsetReg       <= i_addr[1:0];
        accessReg       <= i_memAccess;
        unsignedReg     <= i_memUnsigned;
        isLoadReg       <= ~i_memWrEnable;
        timedOutReg     <= 1'b0;
      end
      if (finishOk || finishTimeout) begin
        o_busRdEnable   <= 1'b0;
        o_busWrEnable   <= 1'b0;
        o_busByteEnable <= 4'b0000;
        timedOutReg     <= finishTimeout;
      end
      if (finishOk && isLoadReg) begin
        rdDataReg <= loadData;
      end
    end
  end

  assign o_rdData   = rdDataReg;
  assign o_rdValid  = (stateReg == DONE) & isLoadReg & ~timedOutReg;
  assign o_busError = (stateReg == DONE) & timedOutReg;

endmodule

// File: tb/tb_mem_stage_controller.sv
module tb_mem_stage_controller;

  localparam int TO = 6;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_isValid = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wrData = '0;
  logic        i_memWrEnable = 1'b0;
  logic        i_memRdEnable = 1'b0;
  logic [1:0]  i_memAccess = 2'b00;
  logic        i_memUnsigned = 1'b0;
  logic        o_stall;
  logic [31:0] o_rdData;
  logic        o_rdValid;
  logic        o_misaligned;
  logic        o_busError;
  logic [31:0] o_busAddr;
  logic        o_busRdEnable;
  logic        o_busWrEnable;
  logic [3:0]  o_busByteEnable;
  logic [31:0] o_busWrData;
  logic [31:0] i_busRdData = '0;
  logic        i_busReady = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] modelRdData = '0;

  mem_stage_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_isValid(i_isValid), .i_addr(i_addr),
    .i_wrData(i_wrData), .i_memWrEnable(i_memWrEnable), .i_memRdEnable(i_memRdEnable),
    .i_memAccess(i_memAccess), .i_memUnsigned(i_memUnsigned), .o_stall(o_stall),
    .o_rdData(o_rdData), .o_rdValid(o_rdValid), .o_misaligned(o_misaligned),
    .o_busError(o_busError), .o_busAddr(o_busAddr), .o_busRdEnable(o_busRdEnable),
    .o_busWrEnable(o_busWrEnable), .o_busByteEnable(o_busByteEnable),
    .o_busWrData(o_busWrData), .i_busRdData(i_busRdData), .i_busReady(i_busReady)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sizeOf(input logic [1:0] acc);
    case (acc)
      2'b00:   sizeOf = 1;
      2'b01:   sizeOf = 2;
      2'b10:   sizeOf = 4;
      default: sizeOf = 0;
    endcase
  endfunction

  // delay = number of REQ cycles without ready before ready is given.
  task automatic doAccess(input logic rdEn, input logic wrEn, input logic [1:0] acc,
                          input logic [31:0] addr, input logic [31:0] wrData,
                          input logic uns, input int delay, input logic [31:0] rdWord);
    int size, off, req;
    bit isStore, legal, done, timedOut;
    logic [3:0]  expBe;
    logic [31:0] expWr, expRd;
    size = sizeOf(acc);
    off = int'(addr[1:0]);
    isStore = wrEn;
    legal = (size != 0) && ((off % size) == 0);
    expBe = 4'b0000;
    expWr = '0;
    for (int i = 0; i < 4; i++) begin
      if (isStore && i >= off && i < off + size) expBe[i] = 1'b1;
      if (size != 0) expWr[8*i +: 8] = wrData[8*(i % size) +: 8];
    end
    expRd = rdWord >> (8 * off);
    if (size == 1) begin
      expRd = expRd & 32'hFF;
      if (!uns && expRd >= 32'd128) expRd = expRd + 32'hFFFFFF00;
    end else if (size == 2) begin
      expRd = expRd & 32'hFFFF;
      if (!uns && expRd >= 32'd32768) expRd = expRd + 32'hFFFF0000;
    end

    i_isValid = 1'b1; i_memRdEnable = rdEn; i_memWrEnable = wrEn;
    i_memAccess = acc; i_addr = addr; i_wrData = wrData; i_memUnsigned = uns;
    i_busReady = 1'($urandom_range(0, 1));
    #1;
    $display("access rd=%0b wr=%0b size=%0d addr=%h wr=%h uns=%0b delay=%0d legal=%0b",
             rdEn, wrEn, size, addr, wrData, uns, delay, legal);
    if (!legal) begin
      check("misaligned_pulse", 32'(o_misaligned), 32'd1);
      check("misaligned_stall", 32'(o_stall), 32'd0);
      check("misaligned_nobus", 32'({o_busRdEnable, o_busWrEnable}), 32'd0);
      @(posedge i_clock); #1;
      i_isValid = 1'b0; i_memRdEnable = 1'b0; i_memWrEnable = 1'b0;
      #1;
      check("misaligned_once", 32'(o_misaligned), 32'd0);
      check("misaligned_nobus_after", 32'({o_busRdEnable, o_busWrEnable}), 32'd0);
      return;
    end
    check("idle_stall", 32'(o_stall), 32'd1);
    check("idle_nomisalign", 32'(o_misaligned), 32'd0);
    @(posedge i_clock); #1;
    req = 0; done = 0; timedOut = 0;
    while (!done) begin
      i_busReady = (req == delay);
      i_busRdData = (req == delay) ? rdWord : $urandom;
      #1;
      check("req_stall", 32'(o_stall), 32'd1);
      check("req_addr", o_busAddr, {addr[31:2], 2'b00});
      check("req_rd", 32'(o_busRdEnable), 32'(!isStore));
      check("req_wr", 32'(o_busWrEnable), 32'(isStore));
      check("req_be", 32'(o_busByteEnable), 32'(expBe));
      if (isStore) check("req_wrdata", o_busWrData, expWr);
      @(posedge i_clock); #1;
      req++;
      if (req == delay + 1) done = 1;
      else if (req == TO) begin done = 1; timedOut = 1; end
    end
    // DONE: the same entry is still presented and must not be re-issued.
    i_busReady = 1'($urandom_range(0, 1));
    i_busRdData = $urandom;
    if (!isStore && !timedOut) modelRdData = expRd;
    #1;
    check("done_stall", 32'(o_stall), 32'd0);
    check("done_rdvalid", 32'(o_rdValid), 32'(!isStore && !timedOut));
    check("done_buserror", 32'(o_busError), 32'(timedOut));
    check("done_rddata", o_rdData, modelRdData);
    check("done_nobus", 32'({o_busRdEnable, o_busWrEnable}), 32'd0);
    @(posedge i_clock); #1;
    i_isValid = 1'b0; i_memRdEnable = 1'b0; i_memWrEnable = 1'b0; i_busReady = 1'b0;
    #1;
    check("idle_rdvalid", 32'(o_rdValid), 32'd0);
    check("idle_buserror", 32'(o_busError), 32'd0);
    check("idle_stall_after", 32'(o_stall), 32'd0);
  endtask

  initial begin
    logic [1:0] acc;
    logic rd, wr;
    int mode;
    repeat (2) @(posedge i_clock);
    #1;
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_rdvalid", 32'(o_rdValid), 32'd0);
    check("rst_misaligned", 32'(o_misaligned), 32'd0);
    check("rst_buserror", 32'(o_busError), 32'd0);
    check("rst_rddata", o_rdData, 32'd0);
    check("rst_busaddr", o_busAddr, 32'd0);
    check("rst_busen", 32'({o_busRdEnable, o_busWrEnable}), 32'd0);
    check("rst_be", 32'(o_busByteEnable), 32'd0);
    check("rst_wrdata", o_busWrData, 32'd0);
    i_reset = 1'b0;
    @(posedge i_clock); #1;

    doAccess(1'b0, 1'b1, 2'b10, 32'h1004, 32'hDEADBEEF, 1'b0, 0, 32'h0);
    doAccess(1'b1, 1'b0, 2'b00, 32'h2003, 32'h0, 1'b0, 0, 32'h80FF1234);
    doAccess(1'b1, 1'b0, 2'b00, 32'h2003, 32'h0, 1'b1, 0, 32'h80FF1234);
    doAccess(1'b1, 1'b0, 2'b01, 32'h2001, 32'h0, 1'b0, 0, 32'h0);
    doAccess(1'b0, 1'b1, 2'b00, 32'h3002, 32'h000000AB, 1'b0, 4, 32'h0);
    doAccess(1'b1, 1'b0, 2'b10, 32'h4000, 32'h0, 1'b0, 1000, 32'h12345678);
    doAccess(1'b1, 1'b0, 2'b01, 32'h4002, 32'h0, 1'b0, TO - 1, 32'h8001_7FFF);
    doAccess(1'b1, 1'b1, 2'b01, 32'h5002, 32'hCAFE1234, 1'b0, 1, 32'h0);
    doAccess(1'b1, 1'b0, 2'b11, 32'h6000, 32'h0, 1'b0, 0, 32'h0);

    // Reset in the middle of REQ.
    i_isValid = 1'b1; i_memRdEnable = 1'b1; i_memWrEnable = 1'b0;
    i_memAccess = 2'b10; i_addr = 32'h7000; i_busReady = 1'b0;
    @(posedge i_clock); #1;
    check("midreq_rd", 32'(o_busRdEnable), 32'd1);
    #2;
    i_reset = 1'b1; i_isValid = 1'b0; i_memRdEnable = 1'b0;
    modelRdData = '0;
    #1;
    $display("reset asserted mid-REQ");
    check("midrst_busen", 32'({o_busRdEnable, o_busWrEnable}), 32'd0);
    check("midrst_stall", 32'(o_stall), 32'd0);
    check("midrst_rddata", o_rdData, 32'd0);
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    @(posedge i_clock); #1;
    doAccess(1'b1, 1'b0, 2'b10, 32'h7000, 32'h0, 1'b0, 0, 32'hA5A55A5A);

    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 2);
      rd = (mode != 1);
      wr = (mode != 0);
      acc = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      doAccess(rd, wr, acc, $urandom, $urandom, 1'($urandom_range(0, 1)),
               $urandom_range(0, TO + 1), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_controller.md
Name: mem_stage_controller

Overview:
Sequences the data-memory access for the instruction held in the EX/MEM pipeline register. It is driven by the EX/MEM outputs (valid, result-as-address, dataB, memWrEnable/memRdEnable, memAccess, memUnsigned). It runs a registered request/ready handshake on the data bus and holds the pipeline via o_stall until the access completes. It also formats byte lanes for stores, extracts and extends load data, and flags misaligned or timed-out accesses.

Parameters:
DATA_WIDTH, 32, data bus and register width (only 32 supported).
ADDR_WIDTH, 32, byte address width.
TIMEOUT, 255, maximum REQ cycles without i_busReady before the access is aborted.

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  asynchronous reset, active-high
i_isValid  in  1  EX/MEM entry valid
i_addr  in  ADDR_WIDTH  byte address (EX/MEM result)
i_wrData  in  DATA_WIDTH  store data (EX/MEM dataB)
i_memWrEnable  in  1  store request
i_memRdEnable  in  1  load request
i_memAccess  in  2  DataAccess: 00 byte, 01 half, 10 word, 11 illegal
i_memUnsigned  in  1  zero-extend load
o_stall  out  1  freeze EX/MEM and all earlier stages
o_rdData  out  DATA_WIDTH  extended load result, valid with o_rdValid
o_rdValid  out  1  one-cycle pulse, load complete
o_misaligned  out  1  one-cycle pulse, misaligned or illegal access, no bus cycle issued
o_busError  out  1  one-cycle pulse, timeout abort
o_busAddr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
o_busRdEnable  out  1  bus read request
o_busWrEnable  out  1  bus write request
o_busByteEnable  out  4  write lane enables
o_busWrData  out  DATA_WIDTH  lane-replicated store data
i_busRdData  in  DATA_WIDTH  bus read word
i_busReady  in  1  bus completes the access this cycle

Behaviour:
- Reset (asynchronous, any state): state=IDLE. All o_bus* = 0. o_rdData=0. o_rdValid, o_misaligned, o_busError = 0. Timeout counter = 0. An in-flight bus request is dropped immediately.
- Access detect: acc = i_isValid & (i_memRdEnable | i_memWrEnable). If both enables are set, the store wins.
- Alignment: byte is always aligned. Half requires addr[0]=0. Word requires addr[1:0]=0. memAccess=11 is always illegal.
- IDLE:
  - acc and aligned: o_stall=1 (combinational). Register the bus outputs, byte offset, access size and unsigned flag. Go to REQ.
  - acc and misaligned/illegal: o_misaligned=1 for this cycle, o_stall=0, no bus activity. Stay in IDLE.
  - otherwise: o_stall=0.
- REQ:
  - o_stall=1. Bus outputs are held stable. The counter increments each cycle.
  - i_busReady=1: for a load, register the formatted i_busRdData into o_rdData. Clear the bus enables. Go to DONE.
  - i_busReady=0 and counter reaches TIMEOUT: clear the bus enables, pulse o_busError, go to DONE. o_rdData is unchanged.
- DONE: o_stall=0, so the pipeline advances exactly once. o_rdValid=1 only if the access was a completed load. Next state is IDLE. Detect is not evaluated in DONE, which prevents re-issuing the same entry.
- Latency: minimum 3 cycles per access (IDLE, REQ with ready, DONE). Each extra REQ cycle adds one.
- Store formatting:
  - Byte: byteEnable = 0001 << addr[1:0], data = {4{wrData[7:0]}}.
  - Half: byteEnable = 0011 << {addr[1],0}, data = {2{wrData[15:0]}}.
  - Word: byteEnable = 1111, data unchanged.
- Reads: byteEnable = 0. Data is shifted right by offset*8, then sign- or zero-extended from bit 7 (byte) or bit 15 (half).
- i_busReady outside REQ is ignored.
- Timeout counter width is clog2(TIMEOUT+1). It clears on entry to REQ.

Decomposition:
- Shared Types package:
  - DataAccess enum (BYTE=00, HALF=01, WORD=10).
  - MemCtrlState enum (IDLE, REQ, DONE).
  - Constants for the byte-enable patterns.
- Sub-module mem_data_aligner: purely combinational store-lane replication, byte enables, load extraction and extension. It is instantiated twice: once for the store path, once for the load path.

Test Plan:
1. SW addr=0x1004, data=0xDEADBEEF, ready on 1st REQ cycle -> busAddr=0x1004, byteEnable=1111, wrData=0xDEADBEEF; stall high 2 cycles; no rdValid.
2. LB addr=0x2003, busRdData=0x80FF1234, signed -> rdData=0xFFFFFF80; same with unsigned -> 0x00000080; rdValid pulses in DONE.
3. LH addr=0x2001 -> o_misaligned=1 for 1 cycle; o_stall=0; busRdEnable never asserted.
4. SB addr=0x3002, data=0x000000AB, ready delayed 5 cycles -> byteEnable=0100, wrData=0xABABABAB held stable; stall high 6 cycles.
5. Load with ready never asserted, TIMEOUT=4 -> busError pulses after 4 REQ cycles; stall released in DONE; rdValid=0.
6. Assert i_reset mid-REQ -> bus enables and o_stall drop immediately; state=IDLE; the next aligned access completes normally.
